// File: rtl/egm_responder.sv
`timescale 1ns/1ps
// EGM responder: synchronizes an asynchronous stimulus, waits a programmable delay, then drives
// a level- or pulse-mode response. An Avalon-MM slave exposes control, timing and event counters.
module egm_responder #(
  parameter int DELAY_W = 16
) (
  input  logic        clkin_50,
  input  logic        rst,
  input  logic        stimulus,
  output logic        response,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [DELAY_W-1:0] cnt_reg, cnt_next, delay_reg, pulse_reg, pulse_last;
  logic               s1_reg, s2_reg, s2_d_reg;
  logic               response_reg, response_next;
  logic               en_reg, mode_reg, pend_reg;
  logic [31:0]        count_reg, missed_reg, readdata_reg, readdata_next;
  logic               rise, wr_ctrl, en_kill, clr, count_inc, missed_inc, start;
  logic               unused_wdata;

  assign rise         = s2_reg & ~s2_d_reg;
  assign wr_ctrl      = avs_write && (avs_address == 3'd0);
  assign en_kill      = wr_ctrl && !avs_writedata[0];
  assign clr          = wr_ctrl && avs_writedata[2];
  // A rise seen while disabled is remembered only as long as the stimulus stays high.
  assign start        = (state_reg == IDLE) && en_reg && (rise || pend_reg);
  assign missed_inc   = rise && (state_reg != IDLE) && !en_kill;
  assign pulse_last   = (pulse_reg == '0) ? '0 : pulse_reg - DELAY_W'(1);
  assign response     = response_reg;
  assign avs_readdata = readdata_reg;
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    response_next = response_reg;
    count_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        response_next = 1'b0;
        if (start) begin
          cnt_next   = delay_reg;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DELAY_W'(1);
        end else begin
          response_next = 1'b1;
          count_inc     = 1'b1;
          cnt_next      = mode_reg ? pulse_last : '0;
          state_next    = RESP;
        end
      end
      RESP: begin
        if (!mode_reg) begin
          if (!s2_reg) begin
            response_next = 1'b0;
            state_next    = IDLE;
          end
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DELAY_W'(1);
        end else begin
          response_next = 1'b0;
          state_next    = s2_reg ? HOLD : IDLE;
        end
      end
      HOLD: begin
        response_next = 1'b0;
        if (!s2_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Disabling aborts whatever is in flight; the increment of that edge is dropped too.
    if (en_kill) begin
      state_next    = IDLE;
      response_next = 1'b0;
      cnt_next      = '0;
      count_inc     = 1'b0;
    end
  end

  always_comb begin
    readdata_next = '0;
    case (avs_address)
      3'd0:    readdata_next = {30'd0, mode_reg, en_reg};
      3'd1:    readdata_next = 32'(delay_reg);
      3'd2:    readdata_next = 32'(pulse_reg);
      3'd3:    readdata_next = count_reg;
      3'd4:    readdata_next = missed_reg;
      3'd5:    readdata_next = {30'd0, response_reg, state_reg != IDLE};
      default: readdata_next = '0;
    endcase
  end

  always_ff @(posedge clkin_50 or posedge rst) begin
    if (rst) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      s2_d_reg     <= 1'b0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      response_reg <= 1'b0;
    end else begin
      s1_reg       <= stimulus;
      s2_reg       <= s1_reg;
      s2_d_reg     <= s2_reg;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      response_reg <= response_next;
    end
  end

  always_ff @(posedge clkin_50 or posedge rst) begin
    if (rst) begin
      en_reg       <= 1'b0;
      mode_reg     <= 1'b0;
      delay_reg    <= '0;
      pulse_reg    <= DELAY_W'(1);
      count_reg    <= '0;
      missed_reg   <= '0;
      pend_reg     <= 1'b0;
      readdata_reg <= '0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          3'd0: begin
            en_reg   <= avs_writedata[0];
            mode_reg <= avs_writedata[1];
          end
          3'd1:    delay_reg <= avs_writedata[DELAY_W-1:0];
          3'd2:    pulse_reg <= avs_writedata[DELAY_W-1:0];
          default: ;
        endcase
      end
      if (clr) count_reg <= '0;
      else if (count_inc && count_reg != '1) count_reg <= count_reg + 32'd1;
      if (clr) missed_reg <= '0;
      else if (missed_inc && missed_reg != '1) missed_reg <= missed_reg + 32'd1;
      if (!s2_reg || state_next == WAIT) pend_reg <= 1'b0;
      else if (rise && state_reg == IDLE && !en_reg) pend_reg <= 1'b1;
      // Read data reflects register contents before any same-cycle write.
      readdata_reg <= avs_read ? readdata_next : '0;
    end
  end
endmodule
